// File: rtl/turbo_pkg.sv
// Shared turbo-code definitions: block sizes, interleaver,
// soft-value mapping and encoder FSM states.
package turbo_pkg;

    localparam int INPUT_SIZE  = 5;
    localparam int EXTEND_SIZE = INPUT_SIZE + 2;
    localparam int SOFT_W      = 4;
    localparam int HARD_W      = 3 * EXTEND_SIZE;

    localparam logic [SOFT_W-1:0] SOFT_ONE  = 4'b0111;
    localparam logic [SOFT_W-1:0] SOFT_ZERO = 4'b1001;

    // Interleaver, same table as the decoder side.
    localparam int PI [INPUT_SIZE] = '{0, 4, 2, 1, 3};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ENC  = 3'd1,
        S_SEND = 3'd2,
        S_HOLD = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    // u_k of the block; bit 0 outside the information range.
    function automatic logic info_bit(
        input logic [INPUT_SIZE-1:0] info,
        input logic [2:0]            k
    );
        info_bit = 1'b0;
        for (int i = 0; i < INPUT_SIZE; i++) begin
            if (k == 3'(i)) begin
                info_bit = info[INPUT_SIZE-1-i];
            end
        end
    endfunction

    // Interleaved position pi(k); 0 outside the information range.
    function automatic logic [2:0] pi_of(input logic [2:0] k);
        pi_of = 3'd0;
        for (int i = 0; i < INPUT_SIZE; i++) begin
            if (k == 3'(i)) begin
                pi_of = 3'(PI[i]);
            end
        end
    endfunction

    // Bit plane j of the soft values of every hard bit.
    function automatic logic [HARD_W-1:0] soft_plane(
        input logic [HARD_W-1:0] hard,
        input logic [1:0]        j
    );
        for (int i = 0; i < HARD_W; i++) begin
            soft_plane[i] = hard[i] ? SOFT_ONE[j] : SOFT_ZERO[j];
        end
    endfunction

endpackage

// File: rtl/turbo_encoder_if.sv
// Request/stream bundle between a block source, the turbo
// encoder and the downstream decoder input.
interface turbo_encoder_if;

    logic [turbo_pkg::INPUT_SIZE-1:0] data_i;
    logic                             start_i;
    logic                             busy_o;
    logic [turbo_pkg::HARD_W-1:0]     data_o;
    logic                             start_o;
    logic                             done_o;

    modport master (
        output data_i,
        output start_i,
        input  busy_o,
        input  data_o,
        input  start_o,
        input  done_o
    );

    modport slave (
        input  data_i,
        input  start_i,
        output busy_o,
        output data_o,
        output start_o,
        output done_o
    );

endinterface

// File: rtl/turbo_encoder_rsc_enc.sv
// Recursive systematic convolutional encoder, 5/7 octal,
// one trellis step per enabled cycle with tail forcing.
module rsc_enc (
    input  logic clk_p_i,
    input  logic reset_n_i,
    input  logic clr_i,
    input  logic en_i,
    input  logic tail_i,
    input  logic u_i,
    output logic u_o,
    output logic p_o
);

    logic [1:0] s_q;
    logic [1:0] s_d;
    logic       s1;
    logic       s2;
    logic       a;

    assign s1 = s_q[0];
    assign s2 = s_q[1];

    // Tail input s1^s2 cancels the feedback and drives a to 0.
    always_comb begin
        u_o = tail_i ? (s1 ^ s2) : u_i;
        a   = u_o ^ s1 ^ s2;
        p_o = a ^ s2;
        s_d = {s1, a};
    end

    // Trellis state: cleared per block, shifted per step.
    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s_q <= 2'b00;
        end else if (clr_i) begin
            s_q <= 2'b00;
        end else if (en_i) begin
            s_q <= s_d;
        end
    end

endmodule

// File: rtl/turbo_encoder.sv
// Rate-1/3 turbo encoder: encodes one 5-bit block, then
// streams 4 soft bit planes with the decoder start qualifier.
module turbo_encoder
    import turbo_pkg::*;
(
    input  logic            clk_p_i,
    input  logic            reset_n_i,
    turbo_encoder_if.slave  bus
);

    state_t                  state_q;
    state_t                  state_d;
    logic [2:0]              cnt_q;
    logic [2:0]              cnt_d;
    logic [INPUT_SIZE-1:0]   info_q;
    logic [EXTEND_SIZE-1:0]  sys_q;
    logic [EXTEND_SIZE-1:0]  par1_q;
    logic [EXTEND_SIZE-1:0]  par2_q;
    logic [HARD_W-1:0]       data_q;
    logic [HARD_W-1:0]       data_d;
    logic                    start_q;
    logic                    start_d;
    logic                    done_q;
    logic                    done_d;
    logic                    busy_q;
    logic                    busy_d;

    logic accept;
    logic enc_en;
    logic tail;
    logic u1_in;
    logic u2_in;
    logic u1_eff;
    logic u2_eff;
    logic p1;
    logic p2;

    // busy_q also covers the FIN output cycle, so a request
    // arriving while done_o is shown is still ignored.
    assign accept = (state_q == S_IDLE) && bus.start_i && !busy_q;
    assign enc_en = (state_q == S_ENC);
    assign tail   = (cnt_q >= 3'(INPUT_SIZE));
    assign u1_in  = info_bit(info_q, cnt_q);
    assign u2_in  = info_bit(info_q, pi_of(cnt_q));

    rsc_enc u_rsc1 (
        .clk_p_i   (clk_p_i),
        .reset_n_i (reset_n_i),
        .clr_i     (accept),
        .en_i      (enc_en),
        .tail_i    (tail),
        .u_i       (u1_in),
        .u_o       (u1_eff),
        .p_o       (p1)
    );

    // Encoder-2 tail inputs are not transmitted.
    rsc_enc u_rsc2 (
        .clk_p_i   (clk_p_i),
        .reset_n_i (reset_n_i),
        .clr_i     (accept),
        .en_i      (enc_en),
        .tail_i    (tail),
        .u_i       (u2_in),
        .u_o       (u2_eff),
        .p_o       (p2)
    );

    // State and step/plane counter registers.
    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: 7 trellis steps, 4 planes, hold, finish.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ENC;
                    cnt_d   = 3'd0;
                end
            end
            S_ENC: begin
                if (cnt_q == 3'(EXTEND_SIZE-1)) begin
                    state_d = S_SEND;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_SEND: begin
                if (cnt_q == 3'(SOFT_W-1)) begin
                    state_d = S_HOLD;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_HOLD: state_d = S_FIN;
            S_FIN:  state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Output next-values, registered one cycle behind the state.
    always_comb begin
        data_d  = '0;
        start_d = 1'b0;
        done_d  = 1'b0;
        busy_d  = (state_q != S_IDLE) || (state_d != S_IDLE);
        unique case (state_q)
            S_SEND: begin
                data_d  = soft_plane({sys_q, par1_q, par2_q},
                                     cnt_q[1:0]);
                start_d = 1'b1;
            end
            S_HOLD: start_d = 1'b1;
            S_FIN:  done_d  = 1'b1;
            default: ;
        endcase
    end

    // Block latch and per-step capture of the coded bits.
    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            info_q <= '0;
            sys_q  <= '0;
            par1_q <= '0;
            par2_q <= '0;
        end else if (accept) begin
            info_q <= bus.data_i;
        end else if (enc_en) begin
            sys_q[3'(EXTEND_SIZE-1) - cnt_q]  <= u1_eff;
            par1_q[3'(EXTEND_SIZE-1) - cnt_q] <= p1;
            par2_q[3'(EXTEND_SIZE-1) - cnt_q] <= p2;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_q  <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            start_q <= start_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.data_o  = data_q;
    assign bus.start_o = start_q;
    assign bus.done_o  = done_q;
    assign bus.busy_o  = busy_q;

endmodule

// File: tb/tb_turbo_encoder.sv
// Directed bench for turbo_encoder: cycle-indexed timeline
// of expected outputs built from a block-level code model.
module tb_turbo_encoder;

    localparam int NCYC = 1024;

    logic clk_p_i   = 1'b0;
    logic reset_n_i = 1'b0;

    turbo_encoder_if bus ();

    turbo_encoder dut (
        .clk_p_i   (clk_p_i),
        .reset_n_i (reset_n_i),
        .bus       (bus)
    );

    always #5 clk_p_i = ~clk_p_i;

    int cyc = 0;
    always @(posedge clk_p_i) cyc <= cyc + 1;

    logic [20:0] exp_data  [NCYC];
    bit          exp_start [NCYC];
    bit          exp_done  [NCYC];
    bit          exp_busy  [NCYC];

    int checks = 0;
    int errors = 0;
    int run = 0;
    int done_cnt = 0;
    int blocks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h",
                     name, cyc, act, exp);
        end
    endtask

    // Two RSC(1,5/7) codes: a_k = x_k^a_{k-1}^a_{k-2},
    // parity = a_k^a_{k-2}; tails drive a_k to zero.
    function automatic logic [20:0] model(input logic [4:0] d);
        int pi [5] = '{0, 4, 2, 1, 3};
        logic [6:0] sys;
        logic [6:0] p1;
        logic [6:0] p2;
        bit a1 = 0, a2 = 0, b1 = 0, b2 = 0;
        for (int k = 0; k < 7; k++) begin
            bit u, v, a, b;
            u = (k < 5) ? d[4-k] : (a1 ^ a2);
            a = u ^ a1 ^ a2;
            sys[6-k] = u;
            p1[6-k] = a ^ a2;
            a2 = a1;
            a1 = a;
            v = (k < 5) ? d[4-pi[k]] : (b1 ^ b2);
            b = v ^ b1 ^ b2;
            p2[6-k] = b ^ b2;
            b2 = b1;
            b1 = b;
        end
        return {sys, p1, p2};
    endfunction

    // Bit j of each symbol's soft value (+7 / -7).
    function automatic logic [20:0] plane_of(input logic [20:0] h,
                                             input int j);
        logic [3:0] one;
        logic [3:0] zero;
        logic [20:0] r;
        one  = 4'd7;
        zero = 4'd0 - 4'd7;
        for (int i = 0; i < 21; i++) r[i] = h[i] ? one[j] : zero[j];
        return r;
    endfunction

    task automatic expect_block(input int t, input logic [4:0] d);
        logic [20:0] h;
        h = model(d);
        if (t + 14 < NCYC) begin
            for (int j = 0; j < 4; j++) exp_data[t+9+j] = plane_of(h, j);
            for (int i = 9; i <= 13; i++) exp_start[t+i] = 1'b1;
            exp_done[t+14] = 1'b1;
            for (int i = 1; i <= 14; i++) exp_busy[t+i] = 1'b1;
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk_p_i);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [4:0] d);
        bus.data_i  = d;
        bus.start_i = 1'b1;
        @(posedge clk_p_i);
        #1;
        bus.start_i = 1'b0;
        bus.data_i  = ~d;
    endtask

    task automatic run_block(input logic [4:0] d, input bit stray);
        int c;
        c = cyc;
        expect_block(c, d);
        blocks++;
        pulse_start(d);
        if (stray) begin
            wait_cyc(c + 3);
            pulse_start(d ^ 5'h15);
            wait_cyc(c + 10);
            pulse_start(d ^ 5'h0A);
            wait_cyc(c + 14);
            pulse_start(d ^ 5'h1F);
        end
        wait_cyc(c + 15);
    endtask

    // Compare DUT outputs with the timeline every cycle.
    always @(negedge clk_p_i) begin
        if (cyc >= 1 && cyc < NCYC) begin
            chk("data_o", 32'(bus.data_o), 32'(exp_data[cyc]));
            chk("start_o", 32'(bus.start_o), 32'(exp_start[cyc]));
            chk("done_o", 32'(bus.done_o), 32'(exp_done[cyc]));
            chk("busy_o", 32'(bus.busy_o), 32'(exp_busy[cyc]));
            if (bus.done_o) begin
                chk("start_run", 32'(run), 32'd5);
                done_cnt++;
            end
            run = bus.start_o ? run + 1 : 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish",
                 cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [20:0] h;
        int c;
        for (int i = 0; i < NCYC; i++) begin
            exp_data[i]  = '0;
            exp_start[i] = 1'b0;
            exp_done[i]  = 1'b0;
            exp_busy[i]  = 1'b0;
        end
        bus.data_i  = '0;
        bus.start_i = 1'b0;
        repeat (4) @(posedge clk_p_i);
        #1;
        reset_n_i = 1'b1;

        h = model(5'b00000);
        chk("model_zero", 32'(h), 32'h0);
        chk("plane0_zero", 32'(plane_of(h, 0)), 32'h1FFFFF);
        chk("plane3_zero", 32'(plane_of(h, 3)), 32'h1FFFFF);
        h = model(5'b10000);
        chk("model_10000", 32'(h), 32'h107BF7);
        chk("plane1_10000", 32'(plane_of(h, 1)), 32'h107BF7);
        chk("plane3_10000", 32'(plane_of(h, 3)), 32'h0F8408);
        h = model(5'b00001);
        chk("model_00001", 32'(h),
            32'(21'b0000111_0000101_0111001));

        @(posedge clk_p_i);
        #1;
        run_block(5'b00000, 1'b0);
        run_block(5'b10000, 1'b0);
        run_block(5'b00001, 1'b0);
        run_block(5'b10110, 1'b1);

        c = cyc;
        expect_block(c, 5'b10000);
        pulse_start(5'b10000);
        wait_cyc(c + 11);
        #2;
        reset_n_i = 1'b0;
        for (int i = c + 11; i <= c + 14; i++) begin
            exp_data[i]  = '0;
            exp_start[i] = 1'b0;
            exp_done[i]  = 1'b0;
            exp_busy[i]  = 1'b0;
        end
        #1;
        chk("rst_data_o", 32'(bus.data_o), 32'h0);
        chk("rst_start_o", 32'(bus.start_o), 32'h0);
        chk("rst_busy_o", 32'(bus.busy_o), 32'h0);
        @(posedge clk_p_i);
        #1;
        reset_n_i = 1'b1;
        run_block(5'b10000, 1'b0);

        for (int n = 0; n < 16; n++) begin
            run_block(5'($urandom_range(0, 31)), 1'b0);
        end

        repeat (3) @(posedge clk_p_i);
        #1;
        chk("done_count", 32'(done_cnt), 32'(blocks));
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
